// File: rtl/game_tick_timer_if.sv
// Control/status bundle for game_tick_timer: period load handshake, run control and tick status.
interface game_tick_timer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             load_valid;
    logic [WIDTH-1:0] load_period;
    logic             load_ready;
    logic             start;
    logic             pause;
    logic             stop;
    logic             tick;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic [WIDTH-1:0] tick_count;

    modport master (
        output load_valid, load_period, start, pause, stop,
        input  load_ready, tick, remaining, busy, tick_count
    );

    modport slave (
        input  load_valid, load_period, start, pause, stop,
        output load_ready, tick, remaining, busy, tick_count
    );
endinterface

// File: rtl/game_tick_timer.sv
// Programmable down-counting period timer emitting a one-cycle game-step tick every period.
// Optional macro TICK_COUNT_EN adds a wrapping tick counter on tick_count (tied to 0 otherwise).
module game_tick_timer #(
    parameter int unsigned     WIDTH          = 32,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(1000)
) (
    input logic               clock,
    input logic               reset,
    game_tick_timer_if.slave  bus
);
    // A zero period would never reload sensibly, so it behaves as a period of one.
    localparam logic [WIDTH-1:0] DEFAULT_P = (DEFAULT_PERIOD == '0) ? WIDTH'(1) : DEFAULT_PERIOD;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] period_reg, period_nx;
    logic [WIDTH-1:0] remaining_q, remaining_nx;
    logic             tick_q, tick_nx;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] p_eff;
    logic             go;

    // Next-state and next-output logic; encoding 11 falls into the IDLE branch.
    always_comb begin
        state_nx     = state;
        period_nx    = period_reg;
        remaining_nx = remaining_q;
        tick_nx      = 1'b0;
        load_clamped = (bus.load_period == '0) ? WIDTH'(1) : bus.load_period;
        p_eff        = period_reg;
        go           = bus.start && !bus.pause;

        if (bus.stop) begin
            state_nx     = IDLE;
            remaining_nx = '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.pause) begin
                        state_nx = PAUSED;
                    end else if (remaining_q == '0) begin
                        tick_nx      = 1'b1;
                        remaining_nx = period_reg - WIDTH'(1);
                    end else begin
                        remaining_nx = remaining_q - WIDTH'(1);
                    end
                end
                PAUSED: begin
                    if (bus.load_valid) begin
                        period_nx = load_clamped;
                    end
                    if (go) begin
                        state_nx = RUN;
                    end
                end
                default: begin
                    if (bus.load_valid) begin
                        period_nx = load_clamped;
                        p_eff     = load_clamped;
                    end
                    if (go) begin
                        state_nx     = RUN;
                        remaining_nx = p_eff - WIDTH'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            period_reg  <= DEFAULT_P;
            remaining_q <= '0;
            tick_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            period_reg  <= period_nx;
            remaining_q <= remaining_nx;
            tick_q      <= tick_nx;
        end
    end

`ifdef TICK_COUNT_EN
    logic [WIDTH-1:0] tick_count_q;

    // Counts every edge that raises tick; wraps naturally at 2^WIDTH.
    always_ff @(posedge clock) begin
        if (reset || bus.stop) begin
            tick_count_q <= '0;
        end else if (tick_nx) begin
            tick_count_q <= tick_count_q + WIDTH'(1);
        end
    end

    assign bus.tick_count = tick_count_q;
`else
    assign bus.tick_count = '0;
`endif

    assign bus.tick       = tick_q;
    assign bus.remaining  = remaining_q;
    assign bus.load_ready = (state != RUN);
    assign bus.busy       = (state == RUN) || (state == PAUSED);
endmodule
